ex_operand_stage: RTL

// - ID/EX pipeline register and operand-select front end that directly feeds the ALU (a, b, alu_op).
// - Captures a decoded instruction with a valid/ready handshake.
// - Resolves RAW hazards by forwarding from the MEM and WB stages.
// - Selects rs1/pc for ALU a and rs2/imm for ALU b.
// - Presents the held instruction to the EX/MEM register downstream.

---
 rtl/ex_operand_stage_pkg.sv | 32 +++
 rtl/ex_operand_stage_fwd_mux.sv | 37 +++
 rtl/ex_operand_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: default widths, ALU opcodes
// and operand-source encodings.
package ex_operand_stage_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;
   localparam int OP_W_DEF   = 5;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_SLL  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_SLT  = 5'd8,
      ALU_SLTU = 5'd9
   } alu_op_e;

   typedef enum logic {
      SRC_A_RS1 = 1'b0,
      SRC_A_PC  = 1'b1
   } src_a_e;

   typedef enum logic {
      SRC_B_RS2 = 1'b0,
      SRC_B_IMM = 1'b1
   } src_b_e;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source forwarding mux: MEM beats WB beats the held register value;
// register x0 always reads as zero.
module ex_operand_stage_fwd_mux #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src_addr,
   input  logic [XLEN-1:0]   held_data,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_addr,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   output logic [XLEN-1:0]   fwd_data
);

   function automatic logic fwd_hit(input logic we, input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] src);
      return we && (dst == src);
   endfunction

   // Priority select of the operand value seen by the ALU
   always_comb begin
      fwd_data = {XLEN{1'b0}};
      if (src_addr == {REG_AW{1'b0}}) begin
         fwd_data = {XLEN{1'b0}};
      end else if (fwd_hit(mem_we, mem_addr, src_addr)) begin
         fwd_data = mem_data;
      end else if (fwd_hit(wb_we, wb_addr, src_addr)) begin
         fwd_data = wb_data;
      end else begin
         fwd_data = held_data;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with valid/ready handshake, MEM/WB forwarding and
// ALU operand selection.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int OP_W   = OP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic              id_a_sel,
   input  logic              id_b_sel,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic              id_rd_we,
   input  logic              mem_fwd_we,
   input  logic [REG_AW-1:0] mem_fwd_addr,
   input  logic [XLEN-1:0]   mem_fwd_data,
   input  logic              wb_fwd_we,
   input  logic [REG_AW-1:0] wb_fwd_addr,
   input  logic [XLEN-1:0]   wb_fwd_data,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [OP_W-1:0]   alu_op,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic              ex_rd_we,
   output logic [XLEN-1:0]   ex_store_data
);

   logic              valid_r;
   logic [XLEN-1:0]   pc_r;
   logic [XLEN-1:0]   imm_r;
   logic [REG_AW-1:0] rs1_addr_r;
   logic [REG_AW-1:0] rs2_addr_r;
   logic [XLEN-1:0]   rs1_data_r;
   logic [XLEN-1:0]   rs2_data_r;
   logic [OP_W-1:0]   alu_op_r;
   logic              a_sel_r;
   logic              b_sel_r;
   logic [REG_AW-1:0] rd_addr_r;
   logic              rd_we_r;

   logic              accept_s;
   logic              load_s;
   logic              stall_s;
   logic              rs1_refresh_s;
   logic              rs2_refresh_s;
   logic [XLEN-1:0]   fwd_rs1_s;
   logic [XLEN-1:0]   fwd_rs2_s;

   assign id_ready = !valid_r || ex_ready;
   assign accept_s = id_valid && id_ready;
   assign load_s   = accept_s && !flush;
   assign stall_s  = valid_r && !ex_ready;

   // The WB refresh keeps a stalled consumer correct once its producer retires out of WB
   assign rs1_refresh_s = wb_fwd_we && (wb_fwd_addr == rs1_addr_r) && (rs1_addr_r != {REG_AW{1'b0}});
   assign rs2_refresh_s = wb_fwd_we && (wb_fwd_addr == rs2_addr_r) && (rs2_addr_r != {REG_AW{1'b0}});

   // Valid bit: flush wins over accept, retire clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (accept_s) begin
         valid_r <= 1'b1;
      end else if (ex_ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   // Instruction control fields, loaded only on an unflushed accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r       <= {XLEN{1'b0}};
         imm_r      <= {XLEN{1'b0}};
         rs1_addr_r <= {REG_AW{1'b0}};
         rs2_addr_r <= {REG_AW{1'b0}};
         alu_op_r   <= OP_W'(ALU_ADD);
         a_sel_r    <= 1'b0;
         b_sel_r    <= 1'b0;
         rd_addr_r  <= {REG_AW{1'b0}};
         rd_we_r    <= 1'b0;
      end else if (load_s) begin
         pc_r       <= id_pc;
         imm_r      <= id_imm;
         rs1_addr_r <= id_rs1_addr;
         rs2_addr_r <= id_rs2_addr;
         alu_op_r   <= id_alu_op;
         a_sel_r    <= id_a_sel;
         b_sel_r    <= id_b_sel;
         rd_addr_r  <= id_rd_addr;
         rd_we_r    <= id_rd_we;
      end else begin
         pc_r       <= pc_r;
         imm_r      <= imm_r;
         rs1_addr_r <= rs1_addr_r;
         rs2_addr_r <= rs2_addr_r;
         alu_op_r   <= alu_op_r;
         a_sel_r    <= a_sel_r;
         b_sel_r    <= b_sel_r;
         rd_addr_r  <= rd_addr_r;
         rd_we_r    <= rd_we_r;
      end
   end

   // Source operand data: loaded on accept, refreshed from WB while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_data_r <= {XLEN{1'b0}};
         rs2_data_r <= {XLEN{1'b0}};
      end else if (load_s) begin
         rs1_data_r <= id_rs1_data;
         rs2_data_r <= id_rs2_data;
      end else if (stall_s) begin
         rs1_data_r <= rs1_refresh_s ? wb_fwd_data : rs1_data_r;
         rs2_data_r <= rs2_refresh_s ? wb_fwd_data : rs2_data_r;
      end else begin
         rs1_data_r <= rs1_data_r;
         rs2_data_r <= rs2_data_r;
      end
   end

   ex_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .src_addr  (rs1_addr_r),
      .held_data (rs1_data_r),
      .mem_we    (mem_fwd_we),
      .mem_addr  (mem_fwd_addr),
      .mem_data  (mem_fwd_data),
      .wb_we     (wb_fwd_we),
      .wb_addr   (wb_fwd_addr),
      .wb_data   (wb_fwd_data),
      .fwd_data  (fwd_rs1_s)
   );

   ex_operand_stage_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .src_addr  (rs2_addr_r),
      .held_data (rs2_data_r),
      .mem_we    (mem_fwd_we),
      .mem_addr  (mem_fwd_addr),
      .mem_data  (mem_fwd_data),
      .wb_we     (wb_fwd_we),
      .wb_addr   (wb_fwd_addr),
      .wb_data   (wb_fwd_data),
      .fwd_data  (fwd_rs2_s)
   );

   assign alu_a         = (a_sel_r == SRC_A_PC)  ? pc_r  : fwd_rs1_s;
   assign alu_b         = (b_sel_r == SRC_B_IMM) ? imm_r : fwd_rs2_s;
   assign alu_op        = alu_op_r;
   assign ex_valid      = valid_r;
   assign ex_rd_addr    = rd_addr_r;
   assign ex_rd_we      = valid_r && rd_we_r;
   assign ex_store_data = fwd_rs2_s;

endmodule
